// File: rtl/rat_io_responder.sv
// Board-side responder for the MCU port bus: LED/7-seg/interrupt registers,
// debounced switch and button inputs, and a level interrupt request.
module rat_io_responder #(
  parameter int DB_CYCLES = 500000,
  parameter int N_BTN     = 4
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic [7:0]       IN_PORT,
  output logic             INTV,
  input  logic [7:0]       SWITCHES,
  input  logic [N_BTN-1:0] BUTTONS,
  output logic [7:0]       LEDS,
  output logic [7:0]       SSEG
);

  localparam int NIN = 8 + N_BTN;
  localparam int CW  = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [NIN-1:0]   r_sync1;
  logic [NIN-1:0]   r_sync2;
  logic [NIN-1:0]   r_db;
  logic [CW-1:0]    r_cnt [NIN];
  logic [N_BTN-1:0] r_btn_prev;
  logic [N_BTN-1:0] r_pend;
  logic [N_BTN-1:0] r_mask;
  logic [7:0]       r_leds;
  logic [7:0]       r_sseg;
  logic             r_intv;

  logic [N_BTN-1:0] w_btn_db;
  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] w_ack;
  logic [N_BTN-1:0] w_pend_next;
  logic [N_BTN-1:0] w_mask_next;
  logic             w_wr_leds;
  logic             w_wr_sseg;
  logic             w_wr_mask;
  logic             w_wr_ack;
  logic [7:0]       w_btn8;
  logic [7:0]       w_pend8;
  logic [7:0]       w_mask8;

  // Switches occupy bits [7:0], buttons the bits above them.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      for (int i = 0; i < NIN; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= {BUTTONS, SWITCHES};
      r_sync2 <= r_sync1;
      for (int i = 0; i < NIN; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_btn_db  = r_db[NIN-1:8];
  assign w_wr_leds = IO_STRB && (PORT_ID == 8'h40);
  assign w_wr_sseg = IO_STRB && (PORT_ID == 8'h41);
  assign w_wr_ack  = IO_STRB && (PORT_ID == 8'h42);
  assign w_wr_mask = IO_STRB && (PORT_ID == 8'h43);

  // A new rising edge takes priority over an ack of the same bit.
  assign w_rise      = w_btn_db & ~r_btn_prev;
  assign w_ack       = w_wr_ack ? OUT_PORT[N_BTN-1:0] : '0;
  assign w_pend_next = (r_pend & ~w_ack) | w_rise;
  assign w_mask_next = w_wr_mask ? OUT_PORT[N_BTN-1:0] : r_mask;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_btn_prev <= '0;
      r_pend     <= '0;
      r_mask     <= '0;
      r_leds     <= '0;
      r_sseg     <= '0;
      r_intv     <= 1'b0;
    end else begin
      r_btn_prev <= w_btn_db;
      r_pend     <= w_pend_next;
      r_mask     <= w_mask_next;
      r_intv     <= |(w_pend_next & w_mask_next);
      if (w_wr_leds) r_leds <= OUT_PORT;
      if (w_wr_sseg) r_sseg <= OUT_PORT;
    end
  end

  always_comb begin
    w_btn8  = '0;
    w_pend8 = '0;
    w_mask8 = '0;
    w_btn8[N_BTN-1:0]  = w_btn_db;
    w_pend8[N_BTN-1:0] = r_pend;
    w_mask8[N_BTN-1:0] = r_mask;
  end

  always_comb begin
    IN_PORT = 8'h00;
    case (PORT_ID)
      8'h20:   IN_PORT = r_db[7:0];
      8'h21:   IN_PORT = w_btn8;
      8'h22:   IN_PORT = w_pend8;
      8'h23:   IN_PORT = w_mask8;
      8'h40:   IN_PORT = r_leds;
      8'h41:   IN_PORT = r_sseg;
      default: IN_PORT = 8'h00;
    endcase
  end

  assign LEDS = r_leds;
  assign SSEG = r_sseg;
  assign INTV = r_intv;

endmodule

// File: tb/tb_rat_io_responder.sv
// Bench for rat_io_responder: directed stimulus, a windowed behavioural model
// compared every cycle, and literal expectations for the key scenarios.
module tb_rat_io_responder;

  localparam int DB = 4;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          RESET_N;
  logic [7:0]    PORT_ID;
  logic [7:0]    OUT_PORT;
  logic          IO_STRB;
  logic [7:0]    IN_PORT;
  logic          INTV;
  logic [7:0]    SWITCHES;
  logic [NB-1:0] BUTTONS;
  logic [7:0]    LEDS;
  logic [7:0]    SSEG;

  int n_chk = 0;
  int n_err = 0;

  rat_io_responder #(.DB_CYCLES(DB), .N_BTN(NB)) dut (
    .clk(clk), .RESET_N(RESET_N), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .IN_PORT(IN_PORT), .INTV(INTV), .SWITCHES(SWITCHES),
    .BUTTONS(BUTTONS), .LEDS(LEDS), .SSEG(SSEG)
  );

  always #5 clk = ~clk;

  // Model: an input bit's debounced value flips once the DB most recent
  // samples that have cleared the two-stage synchronizer all disagree with it.
  logic [11:0]   m_hist [0:DB];
  logic [11:0]   m_db, m_db_last, m_raw;
  logic [NB-1:0] m_pend, m_mask, m_ack, m_rise;
  logic [7:0]    m_leds, m_sseg;
  logic          m_intv;
  bit            m_flip;

  function automatic logic [7:0] m_read(input logic [7:0] id);
    case (id)
      8'h20:   return m_db[7:0];
      8'h21:   return {4'h0, m_db[11:8]};
      8'h22:   return {4'h0, m_pend};
      8'h23:   return {4'h0, m_mask};
      8'h40:   return m_leds;
      8'h41:   return m_sseg;
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge RESET_N);
      if (!RESET_N) begin
        for (int j = 0; j <= DB; j++) m_hist[j] = '0;
        m_db = '0; m_db_last = '0; m_pend = '0; m_mask = '0;
        m_leds = '0; m_sseg = '0; m_intv = 1'b0;
      end else begin
        m_rise = m_db[11:8] & ~m_db_last[11:8];
        m_ack  = (IO_STRB && PORT_ID == 8'h42) ? OUT_PORT[NB-1:0] : '0;
        m_pend = (m_pend & ~m_ack) | m_rise;
        if (IO_STRB && PORT_ID == 8'h43) m_mask = OUT_PORT[NB-1:0];
        if (IO_STRB && PORT_ID == 8'h40) m_leds = OUT_PORT;
        if (IO_STRB && PORT_ID == 8'h41) m_sseg = OUT_PORT;
        m_intv = |(m_pend & m_mask);
        m_db_last = m_db;
        for (int b = 0; b < 12; b++) begin
          m_flip = 1'b1;
          for (int j = 1; j <= DB; j++)
            if (m_hist[j][b] == m_db[b]) m_flip = 1'b0;
          if (m_flip) m_db[b] = ~m_db[b];
        end
        m_raw = {BUTTONS, SWITCHES};
        for (int j = DB; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = m_raw;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_leds", LEDS, m_leds);
    chk("model_sseg", SSEG, m_sseg);
    chk("model_intv", {7'd0, INTV}, {7'd0, m_intv});
    chk("model_inport", IN_PORT, m_read(PORT_ID));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    @(posedge clk); #1;
    PORT_ID = id; OUT_PORT = d; IO_STRB = 1'b1;
    @(posedge clk); #1;
    IO_STRB = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] id, input logic [7:0] exp);
    PORT_ID = id;
    @(negedge clk);
    chk(name, IN_PORT, exp);
  endtask

  initial begin
    RESET_N = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0;
    SWITCHES = 8'h00; BUTTONS = '0;
    cyc(3);
    RESET_N = 1'b1;
    cyc(2);

    wr(8'h40, 8'hA5);
    @(negedge clk); chk("leds_write", LEDS, 8'hA5);
    wr(8'h41, 8'h3C);
    @(negedge clk); chk("sseg_write", SSEG, 8'h3C);
    PORT_ID = 8'h40; OUT_PORT = 8'h11; IO_STRB = 1'b0;
    cyc(2);
    @(negedge clk); chk("leds_nostrobe", LEDS, 8'hA5);
    wr(8'h7F, 8'hFF);
    @(negedge clk); chk("leds_badaddr", LEDS, 8'hA5);
    chk("sseg_badaddr", SSEG, 8'h3C);
    rd_chk("mask_badaddr", 8'h23, 8'h00);
    rd_chk("unmapped_read", 8'h7F, 8'h00);

    // Glitch held three sampled edges, then reverted.
    @(posedge clk); #1;
    SWITCHES = 8'h81; PORT_ID = 8'h20;
    repeat (3) @(posedge clk);
    #1 SWITCHES = 8'h00;
    cyc(8);
    rd_chk("glitch_rejected", 8'h20, 8'h00);

    @(posedge clk); #1;
    SWITCHES = 8'h3C; PORT_ID = 8'h20;
    repeat (5) @(posedge clk);
    @(negedge clk); chk("sw_edge5", IN_PORT, 8'h00);
    @(posedge clk);
    @(negedge clk); chk("sw_edge6", IN_PORT, 8'h3C);

    wr(8'h43, 8'h01);
    @(posedge clk); #1 BUTTONS = 4'b0001;
    cyc(10);
    rd_chk("press_pend", 8'h22, 8'h01);
    chk("press_intv", {7'd0, INTV}, 8'h01);
    rd_chk("btn_db", 8'h21, 8'h01);
    wr(8'h42, 8'h01);
    rd_chk("ack_pend", 8'h22, 8'h00);
    chk("ack_intv", {7'd0, INTV}, 8'h00);
    BUTTONS = 4'b0000;
    cyc(10);
    rd_chk("release_no_pend", 8'h22, 8'h00);

    wr(8'h43, 8'h00);
    @(posedge clk); #1 BUTTONS = 4'b0100;
    cyc(10);
    rd_chk("masked_pend", 8'h22, 8'h04);
    chk("masked_intv", {7'd0, INTV}, 8'h00);
    wr(8'h43, 8'h04);
    @(negedge clk); chk("unmask_intv", {7'd0, INTV}, 8'h01);

    wr(8'h42, 8'h04);
    BUTTONS = 4'b0000;
    wr(8'h43, 8'h01);
    cyc(10);
    rd_chk("clear_pend", 8'h22, 8'h00);
    @(posedge clk); #1 BUTTONS = 4'b0001;
    cyc(10);
    rd_chk("collide_setup", 8'h22, 8'h01);
    BUTTONS = 4'b0000;
    cyc(10);
    // Re-press, and ack on exactly the edge where the new rise lands.
    @(posedge clk); #1 BUTTONS = 4'b0001;
    repeat (6) @(posedge clk);
    #1 PORT_ID = 8'h42; OUT_PORT = 8'h01; IO_STRB = 1'b1;
    @(posedge clk); #1 IO_STRB = 1'b0;
    rd_chk("collide_pend", 8'h22, 8'h01);
    chk("collide_intv", {7'd0, INTV}, 8'h01);

    // Asynchronous reset mid-debounce with clk high.
    SWITCHES = 8'hFF;
    cyc(2);
    PORT_ID = 8'h22;
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_leds", LEDS, 8'h00);
    chk("rst_sseg", SSEG, 8'h00);
    chk("rst_intv", {7'd0, INTV}, 8'h00);
    chk("rst_pend", IN_PORT, 8'h00);
    cyc(2);
    RESET_N = 1'b1;
    cyc(12);
    rd_chk("post_rst_sw", 8'h20, 8'hFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
